// File: rtl/syria_pkg.sv
// Definitions shared across the game top: board geometry, keyboard bindings,
// the UART receive FSM states and the key-to-command decode.
package syria_pkg;

  localparam int BOARD_HEIGHT = 8;
  localparam int BOARD_WIDTH  = 8;

  localparam logic [7:0] KEY_UP_L     = 8'h77;
  localparam logic [7:0] KEY_UP_U     = 8'h57;
  localparam logic [7:0] KEY_DOWN_L   = 8'h73;
  localparam logic [7:0] KEY_DOWN_U   = 8'h53;
  localparam logic [7:0] KEY_LEFT_L   = 8'h61;
  localparam logic [7:0] KEY_LEFT_U   = 8'h41;
  localparam logic [7:0] KEY_RIGHT_L  = 8'h64;
  localparam logic [7:0] KEY_RIGHT_U  = 8'h44;
  localparam logic [7:0] KEY_CENTER   = 8'h20;

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  typedef struct packed {
    logic center;
    logic right;
    logic left;
    logic down;
    logic up;
  } cmd_t;

  function automatic cmd_t decode_key(input logic [7:0] key);
    cmd_t c;
    c = '0;
    case (key)
      KEY_UP_L,    KEY_UP_U:    c.up     = 1'b1;
      KEY_DOWN_L,  KEY_DOWN_U:  c.down   = 1'b1;
      KEY_LEFT_L,  KEY_LEFT_U:  c.left   = 1'b1;
      KEY_RIGHT_L, KEY_RIGHT_U: c.right  = 1'b1;
      KEY_CENTER:               c.center = 1'b1;
      default:                  c        = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: two-flop synchroniser, framing FSM, baud counter and shift register.
// commit/commit_byte expose the byte one cycle early so a registered decoder can align with rx_valid.
module uart_rx_core
  import syria_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       commit,
  output logic [7:0] commit_byte
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_meta_q, rxs_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rxs_q) state_d = IDLE;
      end
      IDLE: begin
        cnt_d = '0;
        if (!rxs_q) begin
          state_d   = START;
          bit_cnt_d = '0;
        end
      end
      START: begin
        // Mid-start-bit check rejects line glitches shorter than half a bit.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rxs_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          shift_d   = {rxs_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (rxs_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = WAIT_HIGH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= WAIT_HIGH;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rxd;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = ferr_q;
  assign commit      = valid_d;
  assign commit_byte = shift_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// Keyboard command receiver: UART byte reception plus a registered key decoder
// whose one-cycle pulses coincide with rx_valid.
module uart_cmd_rx
  import syria_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       cmd_up,
  output logic       cmd_down,
  output logic       cmd_left,
  output logic       cmd_right,
  output logic       cmd_center
);

  logic       commit;
  logic [7:0] commit_byte;
  cmd_t       cmd_q, cmd_d;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .rxd        (RxD),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .commit     (commit),
    .commit_byte(commit_byte)
  );

  always_comb begin
    cmd_d = '0;
    if (commit) cmd_d = decode_key(commit_byte);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cmd_q <= '0;
    else     cmd_q <= cmd_d;
  end

  assign cmd_up     = cmd_q.up;
  assign cmd_down   = cmd_q.down;
  assign cmd_left   = cmd_q.left;
  assign cmd_right  = cmd_q.right;
  assign cmd_center = cmd_q.center;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx at 16 clocks per bit.
module tb_uart_cmd_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RxD = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err;
  logic       cmd_up, cmd_down, cmd_left, cmd_right, cmd_center;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .RxD       (RxD),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .cmd_up    (cmd_up),
    .cmd_down  (cmd_down),
    .cmd_left  (cmd_left),
    .cmd_right (cmd_right),
    .cmd_center(cmd_center)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] kind;   // {rx_valid, frame_err}
    logic [7:0] data;
    logic [4:0] cmd;    // {center, right, left, down, up}
    int         due;
  } evt_t;

  evt_t       sb[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] last_good = 8'h00;
  wire  [4:0] cmd_vec = {cmd_center, cmd_right, cmd_left, cmd_down, cmd_up};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h at cyc %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [4:0] key_cmd(input logic [7:0] b);
    case (b)
      8'h77, 8'h57: return 5'b00001;
      8'h73, 8'h53: return 5'b00010;
      8'h61, 8'h41: return 5'b00100;
      8'h64, 8'h44: return 5'b01000;
      8'h20:        return 5'b10000;
      default:      return 5'b00000;
    endcase
  endfunction

  // Any output pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && (rx_valid || frame_err || (cmd_vec != 5'b0))) begin
      if (sb.size() == 0) begin
        chk("unexpected_evt", {25'b0, rx_valid, frame_err, cmd_vec}, 32'h0);
      end else begin
        evt_t e;
        e = sb.pop_front();
        chk("kind", {30'b0, rx_valid, frame_err}, {30'b0, e.kind});
        chk("rx_data", {24'b0, rx_data}, {24'b0, e.data});
        chk("cmd", {27'b0, cmd_vec}, {27'b0, e.cmd});
        chk("latency", cyc, e.due);
      end
    end
  end

  task automatic idle_bits(input int n);
    RxD = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  // Called on a falling clock edge; cycle 0 is the cycle in which the start bit appears.
  task automatic send_byte(input logic [7:0] b);
    evt_t e;
    e.kind = 2'b10;
    e.data = b;
    e.cmd  = key_cmd(b);
    e.due  = cyc + 3 + CPB / 2 + 9 * CPB;
    sb.push_back(e);
    last_good = b;
    RxD = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (CPB) @(negedge clk);
    end
    RxD = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 20 * CPB;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk(tag, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    evt_t fe;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {23'b0, rx_data, rx_valid, cmd_vec}, 32'h0);
    chk("reset_ferr", {31'b0, frame_err}, 32'h0);
    rst = 1'b0;
    idle_bits(2);

    send_byte(8'h77);
    drain("drain_w");

    send_byte(8'h41);
    idle_bits(1);
    send_byte(8'h5A);
    drain("drain_A_Z");

    RxD = 1'b0;
    repeat (5) @(negedge clk);
    idle_bits(3);
    send_byte(8'h64);
    drain("drain_glitch_d");

    fe.kind = 2'b01;
    fe.data = last_good;
    fe.cmd  = 5'b0;
    fe.due  = cyc + 3 + CPB / 2 + 9 * CPB;
    sb.push_back(fe);
    RxD = 1'b0;
    repeat (29 * CPB) @(negedge clk);
    chk("ferr_seen", sb.size(), 0);
    idle_bits(2);
    send_byte(8'h20);
    drain("drain_ferr_space");

    send_byte(8'h73);
    send_byte(8'h44);
    drain("drain_b2b");
    idle_bits(2);

    // Partial 0x51 frame: start, bits 0..2, then reset half-way into bit 3 (low).
    RxD = 1'b0;
    repeat (CPB) @(negedge clk);
    RxD = 1'b1;
    repeat (CPB) @(negedge clk);
    RxD = 1'b0;
    repeat (3 * CPB + CPB / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", {23'b0, rx_data, rx_valid, cmd_vec}, 32'h0);
    chk("async_rst_ferr", {31'b0, frame_err}, 32'h0);
    last_good = 8'h00;
    @(negedge clk);
    RxD = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    idle_bits(20);
    chk("post_rst_data", {24'b0, rx_data}, 32'h0);
    send_byte(8'h57);
    drain("drain_rst_W");
    idle_bits(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
